// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receive buffer and its neighbours.
// The receiver drives rx_done/rx_data; the host drives rd_en/clr_ovf and
// reads the head byte plus the full/empty/afull/level/overflow status.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic              rx_done;
   logic [7:0]        rx_data;
   logic              rd_en;
   logic              clr_ovf;
   logic [7:0]        rd_data;
   logic              empty;
   logic              full;
   logic              afull;
   logic [ADDR_W:0]   level;
   logic              overflow;

   // slave: the FIFO itself
   modport slave (
      input  rx_done, rx_data, rd_en, clr_ovf,
      output rd_data, empty, full, afull, level, overflow
   );

   // master: the receiver/host side driving the FIFO
   modport master (
      output rx_done, rx_data, rd_en, clr_ovf,
      input  rd_data, empty, full, afull, level, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular byte FIFO behind the UART receiver, first-word-fall-through read.
// Latency: rx_done first sampled high at edge N -> byte written at edge N+2.
// Backpressure: none toward the receiver; a byte arriving while full is dropped and
//               flagged in sticky overflow (cleared by clr_ovf).
// Ports: clk, rst (async active-low); bus (slave) carries rx_done/rx_data in,
//        rd_en/clr_ovf in, rd_data/empty/full/afull/level/overflow out.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,   // power of two, >= 2
   parameter int ADDR_W    = 4,    // log2(DEPTH)
   parameter int AFULL_LVL = 12    // 1..DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   uart_rx_fifo_if.slave   bus
);

   localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W+1)'(AFULL_LVL);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              s1, s2, s3;

   logic              wr_pulse;
   logic              pop;
   logic              push;
   logic              drop;
   logic              empty_i;
   logic              full_i;

   // rx_done comes from the receiver's divided clock: two-flop synchroniser,
   // then s3 remembers the previous synchronised value for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.rx_done;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign wr_pulse = s2 & ~s3;

   assign empty_i = (level == '0);
   assign full_i  = (level == LVL_FULL);

   // A pop in the same cycle frees the slot, so a write into a full FIFO
   // with a concurrent pop is accepted rather than dropped.
   assign pop  = bus.rd_en & ~empty_i;
   assign push = wr_pulse & (~full_i | pop);
   assign drop = wr_pulse & full_i & ~pop;

   // Storage needs no reset; its contents are never visible while empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= bus.rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
         // set has priority over clear
         if (drop)
            overflow <= 1'b1;
         else if (bus.clr_ovf)
            overflow <= 1'b0;
      end
   end

   // Masking with empty gives rd_data=0 during and right after reset even
   // though the storage itself is not cleared.
   assign bus.rd_data  = empty_i ? 8'h00 : mem[rptr];
   assign bus.empty    = empty_i;
   assign bus.full     = full_i;
   assign bus.afull    = (level >= LVL_AFULL);
   assign bus.level    = level;
   assign bus.overflow = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives the receiver and host sides through
// the bus interface and compares outputs against hand-derived values.
module tb_uart_rx_fifo;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   uart_rx_fifo_if #(.ADDR_W(4)) bus ();

   uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_LVL(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the byte already stored.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      repeat (4) @(negedge clk);
      bus.rx_done = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      check(tag, {24'h0, bus.rd_data}, {24'h0, exp});
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_level"},    {27'h0, bus.level}, 32'd0);
      check({tag, "_empty"},    {31'h0, bus.empty}, 32'd1);
      check({tag, "_full"},     {31'h0, bus.full},  32'd0);
      check({tag, "_afull"},    {31'h0, bus.afull}, 32'd0);
      check({tag, "_overflow"}, {31'h0, bus.overflow}, 32'd0);
      check({tag, "_rd_data"},  {24'h0, bus.rd_data}, 32'h0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.rd_en   = 1'b0;
      bus.clr_ovf = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ---- single byte, long rx_done pulse ----
      bus.rx_data = 8'hA5;
      bus.rx_done = 1'b1;
      @(negedge clk);                       // after edge N
      check("t1_empty_n", {31'h0, bus.empty}, 32'd1);
      @(negedge clk);                       // after edge N+1
      check("t1_empty_n1", {31'h0, bus.empty}, 32'd1);
      @(negedge clk);                       // after edge N+2
      check("t1_empty_n2", {31'h0, bus.empty}, 32'd0);
      check("t1_level", {27'h0, bus.level}, 32'd1);
      check("t1_rd_data", {24'h0, bus.rd_data}, 32'hA5);
      repeat (101) @(negedge clk);
      check("t1_level_long", {27'h0, bus.level}, 32'd1);
      bus.rx_done = 1'b0;
      repeat (4) @(negedge clk);
      check("t1_level_after", {27'h0, bus.level}, 32'd1);
      pop_chk("t1_pop", 8'hA5);
      check("t1_empty_end", {31'h0, bus.empty}, 32'd1);

      // ---- fill 16, check flags, drain in order ----
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i));
         check($sformatf("t2_level_%0d", i), {27'h0, bus.level}, 32'(i + 1));
         check($sformatf("t2_afull_%0d", i), {31'h0, bus.afull}, {31'h0, (i + 1) >= 12});
         check($sformatf("t2_full_%0d", i),  {31'h0, bus.full},  {31'h0, (i + 1) == 16});
      end
      for (int i = 0; i < 16; i++)
         pop_chk($sformatf("t2_pop_%0d", i), 8'(i));
      check("t2_empty_end", {31'h0, bus.empty}, 32'd1);
      check("t2_level_end", {27'h0, bus.level}, 32'd0);

      // ---- overflow on full ----
      for (int i = 0; i < 16; i++)
         send_byte(8'(i));
      check("t3_ovf_before", {31'h0, bus.overflow}, 32'd0);
      send_byte(8'hEE);
      check("t3_ovf_set", {31'h0, bus.overflow}, 32'd1);
      check("t3_level", {27'h0, bus.level}, 32'd16);
      for (int i = 0; i < 16; i++)
         pop_chk($sformatf("t3_pop_%0d", i), 8'(i));
      check("t3_ovf_held", {31'h0, bus.overflow}, 32'd1);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      check("t3_ovf_clr", {31'h0, bus.overflow}, 32'd0);

      // ---- write and pop together while full ----
      for (int i = 0; i < 16; i++)
         send_byte(8'(i));
      bus.rx_data = 8'h77;
      bus.rx_done = 1'b1;
      @(negedge clk);                       // after edge N
      @(negedge clk);                       // after edge N+1: wr_pulse now high
      bus.rd_en = 1'b1;                     // pop coincides with write at N+2
      @(negedge clk);
      bus.rd_en = 1'b0;
      check("t4_level", {27'h0, bus.level}, 32'd16);
      check("t4_ovf", {31'h0, bus.overflow}, 32'd0);
      repeat (2) @(negedge clk);
      bus.rx_done = 1'b0;
      repeat (4) @(negedge clk);
      check("t4_level_after", {27'h0, bus.level}, 32'd16);
      for (int i = 1; i < 16; i++)
         pop_chk($sformatf("t4_pop_%0d", i), 8'(i));
      pop_chk("t4_pop_last", 8'h77);
      check("t4_empty_end", {31'h0, bus.empty}, 32'd1);

      // ---- pointer wrap: 40 write/pop pairs ----
      for (int k = 0; k < 40; k++) begin
         send_byte(8'h30 + 8'(k));
         check($sformatf("t5_level_%0d", k), {27'h0, bus.level}, 32'd1);
         pop_chk($sformatf("t5_pop_%0d", k), 8'h30 + 8'(k));
      end
      bus.rd_en = 1'b1;                     // pop on empty is ignored
      repeat (2) @(negedge clk);
      bus.rd_en = 1'b0;
      check("t5_empty_rd_level", {27'h0, bus.level}, 32'd0);
      check("t5_empty_rd_empty", {31'h0, bus.empty}, 32'd1);

      // ---- asynchronous reset at level 5 ----
      for (int i = 0; i < 5; i++)
         send_byte(8'hC0 + 8'(i));
      check("t6_level_pre", {27'h0, bus.level}, 32'd5);
      #2 rst = 1'b0;                        // well away from any clk edge
      #1 check_reset_outputs("t6_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_byte(8'h5A);
      check("t6_level_post", {27'h0, bus.level}, 32'd1);
      pop_chk("t6_pop", 8'h5A);
      check("t6_empty_end", {31'h0, bus.empty}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
